// File: rtl/otter_bus_pkg.sv
// Shared otter_bus types: size encodings, arbiter state, grant type and the
// latched request carried through a shared-bus transfer.
package otter_bus_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

  typedef logic grant_t;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [1:0]       size;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/otter_bus.sv
// otter_bus: single-transfer memory/MMIO bus between a primary and a secondary.
interface otter_bus #(
  parameter int WIDTH = 32
);
  logic             rd;
  logic             wr;
  logic [1:0]       size;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             error;

  modport primary   (output rd, wr, size, addr, wdata, input  rdata, error);
  modport secondary (input  rd, wr, size, addr, wdata, output rdata, error);
endinterface

// File: rtl/otter_bus_arbiter_rr_arb2.sv
// Combinational two-way picker: a lone requester wins; a tie goes to
// requester 0 under fixed priority, otherwise to whoever was not granted last.
module rr_arb2
  import otter_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  grant_t     last_grant_i,
  input  logic       fixed_prio_i,
  output grant_t     winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = fixed_prio_i ? 1'b0 : ~last_grant_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/otter_bus_arbiter.sv
// Shares one otter_bus secondary between two primaries: latch the winner,
// run it for LATENCY+1 cycles on the shared bus, return the response to it.
module otter_bus_arbiter
  import otter_bus_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  otter_bus.secondary m0,
  output logic       m0_stall,
  otter_bus.secondary m1,
  output logic       m1_stall,
  otter_bus.primary  s
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

  arb_state_t       state_q, state_d;
  grant_t           grant_q, grant_d;
  grant_t           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_req_t         lat_q, lat_d;
  bus_req_t         pick;
  grant_t           winner;
  logic             arb_vld;
  logic [1:0]       req;
  logic             done;

  assign req  = {m1.rd | m1.wr, m0.rd | m0.wr};
  assign done = (state_q == XFER) && (cnt_q == CNT_LAST);

  rr_arb2 u_arb (
    .req_i        (req),
    .last_grant_i (last_q),
    .fixed_prio_i (FIXED_PRIO),
    .winner_o     (winner),
    .valid_o      (arb_vld)
  );

  // A simultaneous rd+wr is a write, so rd is masked when latching.
  always_comb begin
    if (winner) begin
      pick.rd    = m1.rd & ~m1.wr;
      pick.wr    = m1.wr;
      pick.size  = m1.size;
      pick.addr  = BUS_W'(m1.addr);
      pick.wdata = BUS_W'(m1.wdata);
    end else begin
      pick.rd    = m0.rd & ~m0.wr;
      pick.wr    = m0.wr;
      pick.size  = m0.size;
      pick.addr  = BUS_W'(m0.addr);
      pick.wdata = BUS_W'(m0.wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = XFER;
          grant_d = winner;
          last_d  = winner;
          cnt_d   = '0;
          lat_d   = pick;
        end
      end
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes pulse only on the first XFER cycle so MMIO side effects happen once.
  always_comb begin
    s.rd     = 1'b0;
    s.wr     = 1'b0;
    s.size   = '0;
    s.addr   = '0;
    s.wdata  = '0;
    m0.rdata = '0;
    m0.error = 1'b0;
    m1.rdata = '0;
    m1.error = 1'b0;
    if (state_q == XFER) begin
      s.rd    = lat_q.rd;
      s.wr    = lat_q.wr & (cnt_q == '0);
      s.size  = lat_q.size;
      s.addr  = WIDTH'(lat_q.addr);
      s.wdata = WIDTH'(lat_q.wdata);
    end
    if (done && !grant_q) begin
      m0.rdata = s.rdata;
      m0.error = s.error;
    end
    if (done && grant_q) begin
      m1.rdata = s.rdata;
      m1.error = s.error;
    end
    m0_stall = req[0] & ~(done & ~grant_q);
    m1_stall = req[1] & ~(done & grant_q);
  end

endmodule

// File: tb/tb_otter_bus_arbiter.sv
// Randomized bench: four arbiter configurations driven by stall-respecting
// random requesters and compared every cycle against a transaction-level model.
module tb_otter_bus_arbiter;
  import otter_bus_pkg::*;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m_rd    [NC][2];
  logic        m_wr    [NC][2];
  logic [1:0]  m_size  [NC][2];
  logic [31:0] m_addr  [NC][2];
  logic [31:0] m_wdata [NC][2];
  logic [31:0] s_rdata [NC];
  logic        s_error [NC];

  logic [NC-1:0]         o_srd, o_swr;
  logic [NC-1:0][1:0]    o_ssize;
  logic [NC-1:0][31:0]   o_saddr, o_swdata;
  logic [2*NC-1:0][31:0] o_rdata;
  logic [2*NC-1:0]       o_err, o_stall;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic bit fp_of(input int k);
    return (k == 3);
  endfunction

  generate
    for (genvar g = 0; g < NC; g++) begin : g_cfg
      localparam int L  = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 2;
      localparam bit FP = (g == 3);
      otter_bus #(.WIDTH(32)) b0 ();
      otter_bus #(.WIDTH(32)) b1 ();
      otter_bus #(.WIDTH(32)) bs ();

      assign b0.rd    = m_rd[g][0];
      assign b0.wr    = m_wr[g][0];
      assign b0.size  = m_size[g][0];
      assign b0.addr  = m_addr[g][0];
      assign b0.wdata = m_wdata[g][0];
      assign b1.rd    = m_rd[g][1];
      assign b1.wr    = m_wr[g][1];
      assign b1.size  = m_size[g][1];
      assign b1.addr  = m_addr[g][1];
      assign b1.wdata = m_wdata[g][1];
      assign bs.rdata = s_rdata[g];
      assign bs.error = s_error[g];

      otter_bus_arbiter #(.WIDTH(32), .LATENCY(L), .FIXED_PRIO(FP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (b0),
        .m0_stall (o_stall[2*g]),
        .m1       (b1),
        .m1_stall (o_stall[2*g+1]),
        .s        (bs)
      );

      assign o_srd[g]       = bs.rd;
      assign o_swr[g]       = bs.wr;
      assign o_ssize[g]     = bs.size;
      assign o_saddr[g]     = bs.addr;
      assign o_swdata[g]    = bs.wdata;
      assign o_rdata[2*g]   = b0.rdata;
      assign o_rdata[2*g+1] = b1.rdata;
      assign o_err[2*g]     = b0.error;
      assign o_err[2*g+1]   = b1.error;
    end
  endgenerate

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transfer per configuration, described by
  // elapsed XFER cycles and the request captured when it was granted.
  bit          act [NC];
  int          ph  [NC];
  bit          win [NC];
  bit          last [NC];
  bit          l_rd [NC];
  bit          l_wr [NC];
  logic [1:0]  l_size [NC];
  logic [31:0] l_addr [NC];
  logic [31:0] l_wdata [NC];
  bit          prev_stall [NC][2];

  task automatic drive(input int req_pct, input int drop_pct);
    int op;
    for (int k = 0; k < NC; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(prev_stall[k][i] && int'($urandom_range(0, 99)) >= drop_pct)) begin
          if (int'($urandom_range(0, 99)) < req_pct) begin
            op = int'($urandom_range(1, 3));
            m_rd[k][i] = (op != 2);
            m_wr[k][i] = (op != 1);
          end else begin
            m_rd[k][i] = 1'b0;
            m_wr[k][i] = 1'b0;
          end
          case ($urandom_range(0, 2))
            0:       m_size[k][i] = BYTE;
            1:       m_size[k][i] = HALF;
            default: m_size[k][i] = WORD;
          endcase
          m_addr[k][i]  = $urandom;
          m_wdata[k][i] = $urandom;
        end
      end
      s_rdata[k] = $urandom;
      s_error[k] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic step();
    bit [1:0]    req;
    bit          done, served, w;
    logic [31:0] e_rdata;
    for (int k = 0; k < NC; k++) begin
      req  = {m_rd[k][1] | m_wr[k][1], m_rd[k][0] | m_wr[k][0]};
      done = act[k] && (ph[k] == lat_of(k));
      check($sformatf("c%0d s.rd", k), 32'(o_srd[k]), 32'(act[k] && l_rd[k]));
      check($sformatf("c%0d s.wr", k), 32'(o_swr[k]), 32'(act[k] && l_wr[k] && ph[k] == 0));
      check($sformatf("c%0d s.size", k), 32'(o_ssize[k]), act[k] ? 32'(l_size[k]) : 32'd0);
      check($sformatf("c%0d s.addr", k), o_saddr[k], act[k] ? l_addr[k] : 32'd0);
      check($sformatf("c%0d s.wdata", k), o_swdata[k], act[k] ? l_wdata[k] : 32'd0);
      for (int i = 0; i < 2; i++) begin
        served  = done && (int'(win[k]) == i);
        e_rdata = served ? s_rdata[k] : 32'd0;
        check($sformatf("c%0d m%0d.rdata", k, i), o_rdata[2*k+i], e_rdata);
        check($sformatf("c%0d m%0d.error", k, i), 32'(o_err[2*k+i]), 32'(served && s_error[k]));
        check($sformatf("c%0d m%0d_stall", k, i), 32'(o_stall[2*k+i]), 32'(req[i] && !served));
        prev_stall[k][i] = req[i] && !served;
      end
      if (!rst_n) begin
        act[k]  = 1'b0;
        last[k] = 1'b1;
      end else if (act[k]) begin
        if (done) act[k] = 1'b0;
        else      ph[k]  = ph[k] + 1;
      end else if (req != 2'b00) begin
        if (req == 2'b01)      w = 1'b0;
        else if (req == 2'b10) w = 1'b1;
        else                   w = fp_of(k) ? 1'b0 : !last[k];
        act[k]     = 1'b1;
        ph[k]      = 0;
        win[k]     = w;
        last[k]    = w;
        l_rd[k]    = m_rd[k][w] && !m_wr[k][w];
        l_wr[k]    = m_wr[k][w];
        l_size[k]  = m_size[k][w];
        l_addr[k]  = m_addr[k][w];
        l_wdata[k] = m_wdata[k][w];
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NC; k++) begin
      act[k]  = 1'b0;
      ph[k]   = 0;
      win[k]  = 1'b0;
      last[k] = 1'b1;
      prev_stall[k][0] = 1'b0;
      prev_stall[k][1] = 1'b0;
    end
    drive(100, 0);
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (cyc < 4) begin
        rst_n = 1'b0;
        drive(100, 0);
      end else if (cyc < 300) begin
        rst_n = 1'b1;
        drive(100, 0);
      end else if (cyc < 1500) begin
        rst_n = 1'b1;
        drive(50, 5);
      end else begin
        rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
        drive(40, 0);
      end
      #1;
      step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
